autoconfig_zii_multi: RTL and testbench
=======================================

// Module: autoconfig_zii_multi
// PURPOSE
//  Parametrised Zorro II AutoConfig engine for NUM_BOARDS logical boards (RAM, IDE, ...) in one CPLD.
//  Presents each board's config ROM nybbles in $E80000 space in order, latches the assigned base, then advances.
//  Sits between the CPU bus (A/D/AS/DS/RW) and the fast-RAM/IDE decoders that consume BASE/CONFIGURED_n.
//  Drives CFGOUT_n once every enabled board is configured or shut up.
// PARAMETERS
//  NUM_BOARDS   2             number of logical boards, 1..4
//  MANUF_ID     16'h0A1C      manufacturer ID shared by all boards
//  SERIAL       32'h0000_0001 serial number shared by all boards
//  PRODUCT_IDS  {8'h02,8'h01} packed 8 bits/board, board 0 in LSBs
//  SIZE_CODES   {3'd0,3'd0}   packed 3 bits/board: Z2 size code (0=8MB, 7=4MB, 1=64KB ...)
//  MEMLIST      2'b01         per-board "link into free memory list" bit
//  ROMVEC       2'b10         per-board "diag ROM valid" bit (autoboot)
// PORTS
//  C7M            in   1             system clock, all logic on rising edge
//  RESET          in   1             synchronous reset, active-high
//  BOARD_EN       in   NUM_BOARDS    per-board enable (jumper); 0 = board skipped
//  CFGIN_n        in   1             daisy-chain input, low = our turn
//  AS_n           in   1             CPU address strobe
//  DS_n           in   1             CPU data strobe (UDS_n & LDS_n)
//  RW_n           in   1             1 = read
//  A_HIGH         in   8             A[23:16]
//  A_LOW          in   6             A[6:1]
//  D_IN           in   4             D[15:12] write nybble
//  D_OUT          out  4             D[15:12] read nybble
//  D_OE           out  1             drive D[15:12]
//  BASE           out  8*NUM_BOARDS  assigned A[23:16] per board
//  CONFIGURED_n   out  NUM_BOARDS    low = board configured
//  CFGOUT_n       out  1             daisy-chain output
// BEHAVIOUR
//  - Reset: D_OUT=0, D_OE=0, BASE=0, CONFIGURED_n=all 1, CFGOUT_n=1, cur=first enabled board, state IDLE.
//  - AS_n/DS_n registered once; cycle start = registered AS_n 1->0. Other inputs sampled when DS_n registered low.
//  - Hit = A_HIGH==8'hE8 & !CFGIN_n & !done. done = no enabled unconfigured board remains.
//  - FSM: IDLE -(hit & DS low)-> ACCESS -> WAIT_END -(AS_n high)-> IDLE. One read/write action per AS cycle.
//  - ACCESS read: D_OUT valid and D_OE=1 on the clock after DS sampled low; held until AS_n sampled high; then D_OE=0.
//  - ROM map for cur, by {A_LOW,1'b0}:
//    $00 = {2'b11,MEMLIST,ROMVEC}; $02 = {1'b0,SIZE} (both true polarity).
//    $04/$06 = ~PRODUCT hi/lo. $10..$16 = ~MANUF_ID nybbles, MSB first. $18..$26 = ~SERIAL nybbles, MSB first.
//    All other offsets = 4'hF (inverted zero).
//  - Write $4A: latch low nybble (A19-16) into pending base.
//  - Write $48: BASE[cur] = {D_IN, pending_lo}; CONFIGURED_n[cur]=0; cur advances to next enabled unconfigured board.
//    Pending base cleared to 0 on advance.
//  - Writes to any other offset are ignored. Writes never assert D_OE.
//  - cur skips boards with BOARD_EN=0. BOARD_EN is sampled continuously while IDLE; a change mid-cycle takes effect next IDLE.
//  - CFGOUT_n = 0 one clock after done becomes true. Stays 0 until RESET.
//  - All boards disabled: done at reset release, CFGOUT_n=0 after one clock, never responds.
//  - RESET mid-cycle (D_OE=1): everything returns to reset values on that edge, D_OE drops immediately.
//  - Only the Z2 config window is decoded. Board address decode belongs to consumer blocks.
// CONFIGURATION
//  AUTOCONFIG_SHUTUP_EN defined:
//    a write to $4C marks cur as shut up: CONFIGURED_n[cur] stays 1, BASE[cur]=0, cur advances, and the board counts as done.
//  Not defined: $4C writes are ignored. A board is left only via a $48 write.
// TESTING
//  1. NUM_BOARDS=2, both enabled. Read $00,$02 -> 4'hE,4'h0 (board 0). Read $04 -> 4'hF, $06 -> 4'hE.
//  2. Write $4A=4'h0, $48=4'h2 -> BASE[7:0]=8'h20, CONFIGURED_n=2'b10. Next read $06 returns board 1 (~2 lo = 4'hD).
//  3. Configure board 1 at 8'hE9 -> CONFIGURED_n=2'b00. CFGOUT_n=0 one clock later. Further $E8 reads -> D_OE stays 0.
//  4. BOARD_EN=2'b01. Configure board 0 -> CFGOUT_n=0 without board 1 ever appearing.
//  5. CFGIN_n=1: reads/writes at $E80000 -> no D_OE, BASE unchanged.
//     Assert RESET during a read with D_OE=1 -> D_OE=0 and CONFIGURED_n=all 1 next edge.
//  6. AUTOCONFIG_SHUTUP_EN: write $4C on board 0 -> CONFIGURED_n[0]=1, board 1 presented. Without macro -> board 0 still presented.

Source files
------------

// File: rtl/autoconfig_zii_multi_if.sv
// CPU-side Zorro II bus bundle for the AutoConfig engine.
// The master drives strobes, address and write data; the slave returns the read nybble and its enable.
interface autoconfig_zii_multi_if;
   logic       AS_n;
   logic       DS_n;
   logic       RW_n;
   logic [7:0] A_HIGH;
   logic [5:0] A_LOW;
   logic [3:0] D_IN;
   logic [3:0] D_OUT;
   logic       D_OE;

   modport master (
      output AS_n, DS_n, RW_n, A_HIGH, A_LOW, D_IN,
      input  D_OUT, D_OE
   );

   modport slave (
      input  AS_n, DS_n, RW_n, A_HIGH, A_LOW, D_IN,
      output D_OUT, D_OE
   );
endinterface

// File: rtl/autoconfig_zii_multi.sv
// Zorro II AutoConfig engine for NUM_BOARDS logical boards sharing one slot.
// Boards are presented one at a time in the $E80000 window in index order,
// skipping disabled ones; each leaves the window on a $48 base write.
// Optional feature macro: AUTOCONFIG_SHUTUP_EN (enables $4C shut-up writes).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a decoded config-window access; BOARD_EN tracked
// S_ACCESS   | one-clock action slot: read data already driven, write applied
// S_WAIT_END | holding read data until AS_n returns high
module autoconfig_zii_multi #(
   parameter int                        NUM_BOARDS  = 2,
   parameter logic [15:0]               MANUF_ID    = 16'h0A1C,
   parameter logic [31:0]               SERIAL      = 32'h0000_0001,
   parameter logic [8*NUM_BOARDS-1:0]   PRODUCT_IDS = {8'h02, 8'h01},
   parameter logic [3*NUM_BOARDS-1:0]   SIZE_CODES  = {3'd0, 3'd0},
   parameter logic [NUM_BOARDS-1:0]     MEMLIST     = 2'b01,
   parameter logic [NUM_BOARDS-1:0]     ROMVEC      = 2'b10
) (
   input  logic                        C7M,
   input  logic                        RESET,
   input  logic [NUM_BOARDS-1:0]       BOARD_EN,
   input  logic                        CFGIN_n,
   autoconfig_zii_multi_if.slave       bus,
   output logic [8*NUM_BOARDS-1:0]     BASE,
   output logic [NUM_BOARDS-1:0]       CONFIGURED_n,
   output logic                        CFGOUT_n
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_WAIT_END = 2'd2
   } state_t;

   // Register offsets in A[6:1] units ($48 -> 6'h24 etc.)
   localparam logic [5:0] OFS_BASE_HI = 6'h24;
   localparam logic [5:0] OFS_BASE_LO = 6'h25;
   localparam logic [5:0] OFS_SHUTUP  = 6'h26;

   state_t                    state_q, state_d;
   logic                      as_q, as_prev_q, ds_q;
   logic                      armed_q, armed_d;
   logic [NUM_BOARDS-1:0]     en_q, en_d;
   logic [NUM_BOARDS-1:0]     cfg_n_q, cfg_n_d;
   logic [NUM_BOARDS-1:0]     shut_q, shut_d;
   logic [8*NUM_BOARDS-1:0]   base_q, base_d;
   logic [3:0]                pend_lo_q, pend_lo_d;
   logic [3:0]                d_out_q, d_out_d;
   logic                      d_oe_q, d_oe_d;
   logic                      wr_q, wr_d;
   logic [5:0]                wa_q, wa_d;
   logic [3:0]                wd_q, wd_d;
   logic                      cfgout_q, cfgout_d;

   logic [NUM_BOARDS-1:0]     pending;
   logic                      done;
   logic [2:0]                cur_idx;
   logic [7:0]                cur_prod;
   logic [2:0]                cur_size;
   logic                      cur_ml;
   logic                      cur_rv;
   logic                      as_start;
   logic                      hit;
   logic [3:0]                rom_nyb;

   // A board still needs the window if it is enabled and neither configured nor shut up.
   assign pending  = en_q & cfg_n_q & ~shut_q;
   assign done     = ~|pending;
   assign as_start = as_prev_q & ~as_q;
   assign hit      = (bus.A_HIGH == 8'hE8) & ~CFGIN_n & ~done;

   // Current board = lowest-index pending board.
   always_comb begin
      cur_idx = '0;
      for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
         if (pending[i]) cur_idx = 3'(i);
      end
   end

   // Per-board ROM attributes of the current board.
   always_comb begin
      cur_prod = '0;
      cur_size = '0;
      cur_ml   = 1'b0;
      cur_rv   = 1'b0;
      for (int i = 0; i < NUM_BOARDS; i++) begin
         if (3'(i) == cur_idx) begin
            cur_prod = PRODUCT_IDS[i*8 +: 8];
            cur_size = SIZE_CODES[i*3 +: 3];
            cur_ml   = MEMLIST[i];
            cur_rv   = ROMVEC[i];
         end
      end
   end

   // Config ROM nybble for the live address; everything beyond $02 is stored inverted.
   always_comb begin
      rom_nyb = 4'hF;
      case (bus.A_LOW)
         6'h00:   rom_nyb = {2'b11, cur_ml, cur_rv};
         6'h01:   rom_nyb = {1'b0, cur_size};
         6'h02:   rom_nyb = ~cur_prod[7:4];
         6'h03:   rom_nyb = ~cur_prod[3:0];
         6'h08:   rom_nyb = ~MANUF_ID[15:12];
         6'h09:   rom_nyb = ~MANUF_ID[11:8];
         6'h0A:   rom_nyb = ~MANUF_ID[7:4];
         6'h0B:   rom_nyb = ~MANUF_ID[3:0];
         6'h0C:   rom_nyb = ~SERIAL[31:28];
         6'h0D:   rom_nyb = ~SERIAL[27:24];
         6'h0E:   rom_nyb = ~SERIAL[23:20];
         6'h0F:   rom_nyb = ~SERIAL[19:16];
         6'h10:   rom_nyb = ~SERIAL[15:12];
         6'h11:   rom_nyb = ~SERIAL[11:8];
         6'h12:   rom_nyb = ~SERIAL[7:4];
         6'h13:   rom_nyb = ~SERIAL[3:0];
         default: rom_nyb = 4'hF;
      endcase
   end

   // Next-state and action logic for the access FSM.
   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      en_d      = en_q;
      cfg_n_d   = cfg_n_q;
      shut_d    = shut_q;
      base_d    = base_q;
      pend_lo_d = pend_lo_q;
      d_out_d   = d_out_q;
      d_oe_d    = d_oe_q;
      wr_d      = wr_q;
      wa_d      = wa_q;
      wd_d      = wd_q;
      cfgout_d  = cfgout_q & ~done;

      // Remember that an AS cycle began, so a late DS still gets exactly one action.
      if (as_q)          armed_d = 1'b0;
      else if (as_start) armed_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            en_d = BOARD_EN;
            if ((armed_q | as_start) & ~as_q & ~ds_q & hit) begin
               state_d = S_ACCESS;
               armed_d = 1'b0;
               if (bus.RW_n) begin
                  d_oe_d  = 1'b1;
                  d_out_d = rom_nyb;
               end else begin
                  wr_d = 1'b1;
                  wa_d = bus.A_LOW;
                  wd_d = bus.D_IN;
               end
            end
         end
         S_ACCESS: begin
            state_d = S_WAIT_END;
            wr_d    = 1'b0;
            if (wr_q) begin
               case (wa_q)
                  OFS_BASE_LO: pend_lo_d = wd_q;
                  OFS_BASE_HI: begin
                     for (int i = 0; i < NUM_BOARDS; i++) begin
                        if (3'(i) == cur_idx) begin
                           base_d[i*8 +: 8] = {wd_q, pend_lo_q};
                           cfg_n_d[i]       = 1'b0;
                        end
                     end
                     pend_lo_d = 4'h0;
                  end
`ifdef AUTOCONFIG_SHUTUP_EN
                  OFS_SHUTUP: begin
                     for (int i = 0; i < NUM_BOARDS; i++) begin
                        if (3'(i) == cur_idx) begin
                           base_d[i*8 +: 8] = 8'h00;
                           shut_d[i]        = 1'b1;
                        end
                     end
                     pend_lo_d = 4'h0;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_WAIT_END: begin
            if (as_q) begin
               state_d = S_IDLE;
               d_oe_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset also captures the jumpers so done is valid at release.
   always_ff @(posedge C7M) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         as_q      <= 1'b1;
         as_prev_q <= 1'b1;
         ds_q      <= 1'b1;
         armed_q   <= 1'b0;
         en_q      <= BOARD_EN;
         cfg_n_q   <= '1;
         shut_q    <= '0;
         base_q    <= '0;
         pend_lo_q <= 4'h0;
         d_out_q   <= 4'h0;
         d_oe_q    <= 1'b0;
         wr_q      <= 1'b0;
         wa_q      <= 6'h00;
         wd_q      <= 4'h0;
         cfgout_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         as_q      <= bus.AS_n;
         as_prev_q <= as_q;
         ds_q      <= bus.DS_n;
         armed_q   <= armed_d;
         en_q      <= en_d;
         cfg_n_q   <= cfg_n_d;
         shut_q    <= shut_d;
         base_q    <= base_d;
         pend_lo_q <= pend_lo_d;
         d_out_q   <= d_out_d;
         d_oe_q    <= d_oe_d;
         wr_q      <= wr_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         cfgout_q  <= cfgout_d;
      end
   end

   assign bus.D_OUT    = d_out_q;
   assign bus.D_OE     = d_oe_q;
   assign BASE         = base_q;
   assign CONFIGURED_n = cfg_n_q;
   assign CFGOUT_n     = cfgout_q;

endmodule

// File: tb/tb_autoconfig_zii_multi.sv
// Bench for the multi-board AutoConfig engine: read nybbles are queued when a
// read is issued and compared when the engine raises D_OE.
module tb_autoconfig_zii_multi;

   logic       C7M;
   logic       RESET;
   logic [1:0] BOARD_EN;
   logic       CFGIN_n;
   logic [15:0] BASE;
   logic [1:0] CONFIGURED_n;
   logic       CFGOUT_n;

   autoconfig_zii_multi_if bus ();

   autoconfig_zii_multi dut (
      .C7M          (C7M),
      .RESET        (RESET),
      .BOARD_EN     (BOARD_EN),
      .CFGIN_n      (CFGIN_n),
      .bus          (bus.slave),
      .BASE         (BASE),
      .CONFIGURED_n (CONFIGURED_n),
      .CFGOUT_n     (CFGOUT_n)
   );

   initial C7M = 1'b0;
   always #5 C7M = ~C7M;

   typedef struct {
      string      tag;
      logic [3:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every D_OE rising edge must match the oldest queued read.
   logic oe_prev = 1'b0;
   always @(negedge C7M) begin
      if (bus.D_OE === 1'b1 && !oe_prev) begin
         if (sb.size() == 0) begin
            chk("oe_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, {28'h0, bus.D_OUT}, {28'h0, e.d});
         end
      end
      oe_prev = (bus.D_OE === 1'b1);
   end

   // Edge-timing monitor for CONFIGURED_n / CFGOUT_n / reset release.
   int   cyc = 0;
   int   cfgn_chg_cyc = 0;
   int   cfgout_cyc = 0;
   int   rel_cyc = 0;
   logic [1:0] cfgn_prev = 2'b11;
   logic cfgout_prev = 1'b1;
   logic rst_prev = 1'b1;
   always @(posedge C7M) begin
      logic rst_now;
      cyc++;
      rst_now = RESET;
      #1;
      if (CONFIGURED_n !== cfgn_prev) cfgn_chg_cyc = cyc;
      cfgn_prev = CONFIGURED_n;
      if (CFGOUT_n === 1'b0 && cfgout_prev) cfgout_cyc = cyc;
      cfgout_prev = (CFGOUT_n !== 1'b0);
      if (!rst_now && rst_prev) rel_cyc = cyc;
      rst_prev = rst_now;
   end

   task automatic bus_idle();
      bus.AS_n   = 1'b1;
      bus.DS_n   = 1'b1;
      bus.RW_n   = 1'b1;
      bus.A_HIGH = 8'h00;
      bus.A_LOW  = 6'h00;
      bus.D_IN   = 4'h0;
   endtask

   task automatic do_reset(input logic [1:0] en);
      RESET    = 1'b1;
      BOARD_EN = en;
      bus_idle();
      repeat (3) @(negedge C7M);
      RESET = 1'b0;
      @(negedge C7M);
   endtask

   task automatic rd(input string tag, input logic [7:0] ah, input logic [5:0] al,
                     input bit exp_oe, input logic [3:0] exp);
      bit oe_seen;
      oe_seen = 1'b0;
      if (exp_oe) sb.push_back('{tag, exp});
      bus.A_HIGH = ah;
      bus.A_LOW  = al;
      bus.RW_n   = 1'b1;
      bus.AS_n   = 1'b0;
      bus.DS_n   = 1'b0;
      repeat (6) begin
         @(negedge C7M);
         if (bus.D_OE === 1'b1) oe_seen = 1'b1;
      end
      chk({tag, "_oe"}, {31'h0, oe_seen}, {31'h0, exp_oe});
      if (exp_oe && !oe_seen && sb.size() > 0) void'(sb.pop_back());
      bus_idle();
      repeat (4) @(negedge C7M);
      chk({tag, "_oe_off"}, {31'h0, bus.D_OE}, 32'h0);
   endtask

   task automatic wr(input string tag, input logic [7:0] ah, input logic [5:0] al,
                     input logic [3:0] d);
      bit oe_bad;
      oe_bad = 1'b0;
      bus.A_HIGH = ah;
      bus.A_LOW  = al;
      bus.D_IN   = d;
      bus.RW_n   = 1'b0;
      bus.AS_n   = 1'b0;
      bus.DS_n   = 1'b0;
      repeat (5) begin
         @(negedge C7M);
         if (bus.D_OE !== 1'b0) oe_bad = 1'b1;
      end
      bus_idle();
      repeat (3) @(negedge C7M);
      chk({tag, "_no_oe"}, {31'h0, oe_bad}, 32'h0);
   endtask

   initial begin
      bit oe_seen;
      RESET    = 1'b1;
      BOARD_EN = 2'b11;
      CFGIN_n  = 1'b0;
      bus_idle();

      // Reset values
      do_reset(2'b11);
      chk("rst_d_oe",   {31'h0, bus.D_OE}, 32'h0);
      chk("rst_d_out",  {28'h0, bus.D_OUT}, 32'h0);
      chk("rst_base",   {16'h0, BASE}, 32'h0);
      chk("rst_cfgn",   {30'h0, CONFIGURED_n}, 32'h3);
      chk("rst_cfgout", {31'h0, CFGOUT_n}, 32'h1);

      // Board 0 ROM
      rd("b0_r00", 8'hE8, 6'h00, 1, 4'hE);
      rd("b0_r02", 8'hE8, 6'h01, 1, 4'h0);
      rd("b0_r04", 8'hE8, 6'h02, 1, 4'hF);
      rd("b0_r06", 8'hE8, 6'h03, 1, 4'hE);
      rd("b0_r10", 8'hE8, 6'h08, 1, 4'hF);
      rd("b0_r12", 8'hE8, 6'h09, 1, 4'h5);
      rd("b0_r18", 8'hE8, 6'h0C, 1, 4'hF);
      rd("b0_r26", 8'hE8, 6'h13, 1, 4'hE);
      rd("b0_r28", 8'hE8, 6'h14, 1, 4'hF);
      rd("b0_r48", 8'hE8, 6'h24, 1, 4'hF);

      // Configure board 0 at $20; an unrelated write changes nothing
      wr("w40", 8'hE8, 6'h20, 4'h5);
      chk("w40_cfgn", {30'h0, CONFIGURED_n}, 32'h3);
      wr("b0_w4a", 8'hE8, 6'h25, 4'h0);
      wr("b0_w48", 8'hE8, 6'h24, 4'h2);
      chk("b0_base", {16'h0, BASE}, 32'h0020);
      chk("b0_cfgn", {30'h0, CONFIGURED_n}, 32'h2);
      chk("b0_cfgout", {31'h0, CFGOUT_n}, 32'h1);

      // Board 1 ROM
      rd("b1_r06", 8'hE8, 6'h03, 1, 4'hD);
      rd("b1_r00", 8'hE8, 6'h00, 1, 4'hD);

      // Configure board 1 at $E9; daisy chain passes on one clock later
      wr("b1_w4a", 8'hE8, 6'h25, 4'h9);
      wr("b1_w48", 8'hE8, 6'h24, 4'hE);
      chk("b1_base", {16'h0, BASE}, 32'hE920);
      chk("b1_cfgn", {30'h0, CONFIGURED_n}, 32'h0);
      chk("b1_cfgout", {31'h0, CFGOUT_n}, 32'h0);
      chk("b1_cfgout_lat", cfgout_cyc - cfgn_chg_cyc, 1);
      rd("done_r00", 8'hE8, 6'h00, 0, 4'h0);

      // Only board 0 enabled
      do_reset(2'b01);
      chk("en01_cfgout", {31'h0, CFGOUT_n}, 32'h1);
      wr("en01_w4a", 8'hE8, 6'h25, 4'h1);
      wr("en01_w48", 8'hE8, 6'h24, 4'h4);
      chk("en01_base", {16'h0, BASE}, 32'h0041);
      chk("en01_cfgn", {30'h0, CONFIGURED_n}, 32'h2);
      chk("en01_cfgout", {31'h0, CFGOUT_n}, 32'h0);
      rd("en01_r06", 8'hE8, 6'h03, 0, 4'h0);

      // No boards enabled
      do_reset(2'b00);
      chk("en00_cfgout", {31'h0, CFGOUT_n}, 32'h0);
      chk("en00_cfgout_lat", cfgout_cyc - (rel_cyc - 1), 1);
      rd("en00_r00", 8'hE8, 6'h00, 0, 4'h0);

      // Not our turn in the chain, and wrong window
      do_reset(2'b11);
      CFGIN_n = 1'b1;
      rd("cfgin_r00", 8'hE8, 6'h00, 0, 4'h0);
      wr("cfgin_w4a", 8'hE8, 6'h25, 4'h3);
      wr("cfgin_w48", 8'hE8, 6'h24, 4'h4);
      chk("cfgin_base", {16'h0, BASE}, 32'h0);
      chk("cfgin_cfgn", {30'h0, CONFIGURED_n}, 32'h3);
      CFGIN_n = 1'b0;
      rd("e9_r00", 8'hE9, 6'h00, 0, 4'h0);
      wr("e9_w48", 8'hE9, 6'h24, 4'h4);
      chk("e9_cfgn", {30'h0, CONFIGURED_n}, 32'h3);

      // Reset in the middle of a driven read
      wr("mr_w48", 8'hE8, 6'h24, 4'h6);
      chk("mr_cfgn_pre", {30'h0, CONFIGURED_n}, 32'h2);
      sb.push_back('{"mr_r00", 4'hD});
      bus.A_HIGH = 8'hE8;
      bus.A_LOW  = 6'h00;
      bus.RW_n   = 1'b1;
      bus.AS_n   = 1'b0;
      bus.DS_n   = 1'b0;
      oe_seen = 1'b0;
      for (int i = 0; i < 8 && !oe_seen; i++) begin
         @(negedge C7M);
         if (bus.D_OE === 1'b1) oe_seen = 1'b1;
      end
      chk("mr_oe_up", {31'h0, oe_seen}, 32'h1);
      if (!oe_seen && sb.size() > 0) void'(sb.pop_back());
      RESET = 1'b1;
      @(negedge C7M);
      chk("mr_oe_drop", {31'h0, bus.D_OE}, 32'h0);
      chk("mr_cfgn", {30'h0, CONFIGURED_n}, 32'h3);
      chk("mr_base", {16'h0, BASE}, 32'h0);
      bus_idle();
      repeat (2) @(negedge C7M);
      RESET = 1'b0;
      @(negedge C7M);

      // Shut-up write on board 0 (pending low nybble 7 loaded first)
      do_reset(2'b11);
      wr("su_w4a", 8'hE8, 6'h25, 4'h7);
      wr("su_w4c", 8'hE8, 6'h26, 4'h0);
`ifdef AUTOCONFIG_SHUTUP_EN
      chk("su_cfgn", {30'h0, CONFIGURED_n}, 32'h3);
      rd("su_r06", 8'hE8, 6'h03, 1, 4'hD);
      wr("su_w48", 8'hE8, 6'h24, 4'h3);
      chk("su_base", {16'h0, BASE}, 32'h3000);
      chk("su_cfgn2", {30'h0, CONFIGURED_n}, 32'h1);
      chk("su_cfgout", {31'h0, CFGOUT_n}, 32'h0);
`else
      chk("su_cfgn", {30'h0, CONFIGURED_n}, 32'h3);
      rd("su_r06", 8'hE8, 6'h03, 1, 4'hE);
      wr("su_w48", 8'hE8, 6'h24, 4'h3);
      chk("su_base", {16'h0, BASE}, 32'h0037);
      chk("su_cfgn2", {30'h0, CONFIGURED_n}, 32'h2);
      chk("su_cfgout", {31'h0, CFGOUT_n}, 32'h1);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
